// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - synchronous FIFO with programmable almost flags and optional FWFT read
// Occupancy is a registered counter; all status flags decode from it.
module sync_fifo_prog #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almostFull,
  output logic                     almostEmpty,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_acc, wr_acc;

  // A read frees a slot on the same edge, so a full FIFO can still accept a write alongside it.
  always_comb begin
    rd_acc      = rdEn && (count_q != '0);
    wr_acc      = wrEn && ((count_q != DEPTH_C) || rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wrEn && !wr_acc;
    underflow_d = rdEn && !rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr_q] <= wdata;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (rd_acc) rdata_d = mem[rd_ptr_q];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end else begin : g_fwft
      // Forced to zero when empty so reset presents a clean output despite unreset storage.
      assign rdata = (count_q == '0) ? '0 : mem[rd_ptr_q];
    end
  endgenerate

  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostFull  = (count_q >= AF_C);
  assign almostEmpty = (count_q <= AE_C);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - self-checking bench for sync_fifo_prog (standard and FWFT instances)
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wrEn = 1'b0, rdEn = 1'b0;
  logic [7:0] wdata = '0, rdata;
  logic       full, empty, almostFull, almostEmpty, overflow, underflow;
  logic [4:0] count;

  logic       reset_f = 1'b1;
  logic       wr_f = 1'b0, rd_f = 1'b0;
  logic [7:0] wd_f = '0, rdata_f;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [4:0] count_f;

  int passed = 0;
  int total  = 0;

  logic [7:0] sb[$];
  int         m_count = 0;
  logic [7:0] m_rdata = '0;
  logic       exp_ovf = 1'b0, exp_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .wrEn(wrEn), .wdata(wdata), .rdEn(rdEn), .rdata(rdata),
    .full(full), .empty(empty), .almostFull(almostFull), .almostEmpty(almostEmpty),
    .overflow(overflow), .underflow(underflow), .count(count)
  );

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_f (
    .clk(clk), .reset(reset_f), .wrEn(wr_f), .wdata(wd_f), .rdEn(rd_f), .rdata(rdata_f),
    .full(full_f), .empty(empty_f), .almostFull(af_f), .almostEmpty(ae_f),
    .overflow(ovf_f), .underflow(udf_f), .count(count_f)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: decides acceptance, queues expected data, then applies one clock edge.
  task automatic step(input logic w, input logic [7:0] wd, input logic r);
    logic ra, wa;
    ra = r && (m_count != 0);
    wa = w && ((m_count != 16) || ra);
    exp_ovf = w && !wa;
    exp_udf = r && !ra;
    if (ra) m_rdata = sb.pop_front();
    if (wa) sb.push_back(wd);
    m_count = m_count + (wa ? 1 : 0) - (ra ? 1 : 0);
    wrEn = w; wdata = wd; rdEn = r;
    @(posedge clk); #1;
    wrEn = 1'b0; rdEn = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if ({empty, almostEmpty, full, almostFull} !== 4'b1100)
      $display("FAIL reset_flags: got %b want 1100", {empty, almostEmpty, full, almostFull}); else passed++;
    total++; if ({overflow, underflow} !== 2'b00)
      $display("FAIL reset_pulses: got %b want 00", {overflow, underflow}); else passed++;
    total++; if (rdata !== 8'h00) $display("FAIL reset_rdata: got %0h want 00", rdata); else passed++;
    total++; if (count_f !== 5'd0 || empty_f !== 1'b1)
      $display("FAIL reset_fwft: got count %0d empty %b want 0 1", count_f, empty_f); else passed++;
    @(posedge clk); #1;
    reset = 1'b0; reset_f = 1'b0;
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      total++; if (count !== 5'(m_count) || full !== (m_count == 16))
        $display("FAIL fill_%0d: got count %0d full %b want %0d %b", i, count, full, m_count, m_count == 16);
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (rdata !== m_rdata || rdata !== 8'(i))
        $display("FAIL drain_%0d: got %0h want %0h", i, rdata, m_rdata);
      else passed++;
    end
    total++; if (empty !== 1'b1 || count !== 5'd0)
      $display("FAIL drain_empty: got empty %b count %0d want 1 0", empty, count); else passed++;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    total++; if (overflow !== 1'b1 || exp_ovf !== 1'b1 || count !== 5'd16)
      $display("FAIL ovf_first: got ovf %b count %0d want 1 16", overflow, count); else passed++;
    step(1'b1, 8'hAB, 1'b0);
    total++; if (overflow !== 1'b1)
      $display("FAIL ovf_b2b: got %b want 1", overflow); else passed++;
    step(1'b0, 8'h00, 1'b0);
    total++; if (overflow !== 1'b0)
      $display("FAIL ovf_clear: got %b want 0", overflow); else passed++;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (rdata !== m_rdata || rdata === 8'hAA || rdata === 8'hAB)
        $display("FAIL ovf_drain_%0d: got %0h want %0h", i, rdata, m_rdata);
      else passed++;
    end
  endtask

  task automatic test_underflow;
    step(1'b0, 8'h00, 1'b1);
    total++; if (underflow !== 1'b1 || rdata !== m_rdata)
      $display("FAIL udf_first: got udf %b rdata %0h want 1 %0h", underflow, rdata, m_rdata); else passed++;
    step(1'b0, 8'h00, 1'b1);
    total++; if (underflow !== 1'b1)
      $display("FAIL udf_b2b: got %b want 1", underflow); else passed++;
    step(1'b1, 8'h55, 1'b1);
    total++; if (underflow !== 1'b1 || count !== 5'd1 || rdata !== m_rdata)
      $display("FAIL udf_both: got udf %b count %0d rdata %0h want 1 1 %0h", underflow, count, rdata, m_rdata);
    else passed++;
    step(1'b0, 8'h00, 1'b0);
    total++; if (underflow !== 1'b0)
      $display("FAIL udf_clear: got %b want 0", underflow); else passed++;
    step(1'b0, 8'h00, 1'b1);
    total++; if (rdata !== 8'h55 || m_rdata !== 8'h55 || empty !== 1'b1)
      $display("FAIL udf_readback: got %0h empty %b want 55 1", rdata, empty); else passed++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      total++; if (count !== 5'd16 || overflow !== 1'b0 || rdata !== m_rdata)
        $display("FAIL b2b_%0d: got count %0d ovf %b rdata %0h want 16 0 %0h", i, count, overflow, rdata, m_rdata);
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (rdata !== m_rdata)
        $display("FAIL b2b_drain_%0d: got %0h want %0h", i, rdata, m_rdata); else passed++;
    end
  endtask

  task automatic test_flags;
    for (int i = 0; i < 16; i++) begin
      if (m_count == 13) begin
        wrEn = 1'b1; #2;
        total++; if (almostFull !== 1'b0)
          $display("FAIL af_comb: got %b want 0", almostFull); else passed++;
      end
      step(1'b1, 8'(i), 1'b0);
      total++; if ({almostFull, almostEmpty, full, empty} !== {m_count >= 14, m_count <= 2, m_count == 16, m_count == 0})
        $display("FAIL flags_up_%0d: got %b want %b", m_count, {almostFull, almostEmpty, full, empty},
                 {m_count >= 14, m_count <= 2, m_count == 16, m_count == 0});
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_count == 3) begin
        rdEn = 1'b1; #2;
        total++; if (almostEmpty !== 1'b0)
          $display("FAIL ae_comb: got %b want 0", almostEmpty); else passed++;
      end
      step(1'b0, 8'h00, 1'b1);
      total++; if ({almostFull, almostEmpty, full, empty} !== {m_count >= 14, m_count <= 2, m_count == 16, m_count == 0})
        $display("FAIL flags_down_%0d: got %b want %b", m_count, {almostFull, almostEmpty, full, empty},
                 {m_count >= 14, m_count <= 2, m_count == 16, m_count == 0});
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    #2 reset = 1'b1; #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || almostEmpty !== 1'b1 || rdata !== 8'h00)
      $display("FAIL reset_mid: got count %0d empty %b ae %b rdata %0h want 0 1 1 00", count, empty, almostEmpty, rdata);
    else passed++;
    sb.delete(); m_count = 0; m_rdata = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    total++; if (rdata !== 8'h77 || m_rdata !== 8'h77)
      $display("FAIL reset_mid_resume: got %0h want 77", rdata); else passed++;
  endtask

  task automatic test_fwft;
    wr_f = 1'b1; wd_f = 8'h3C;
    @(posedge clk); #1; wr_f = 1'b0;
    total++; if (rdata_f !== 8'h3C || empty_f !== 1'b0)
      $display("FAIL fwft_first: got %0h empty %b want 3c 0", rdata_f, empty_f); else passed++;
    rd_f = 1'b1;
    @(posedge clk); #1; rd_f = 1'b0;
    total++; if (empty_f !== 1'b1)
      $display("FAIL fwft_pop: got empty %b want 1", empty_f); else passed++;
    for (int i = 0; i < 8; i++) begin
      wr_f = 1'b1; wd_f = 8'(i + 1);
      @(posedge clk); #1;
      if (i == 3) begin
        total++; if (count_f !== 5'd4)
          $display("FAIL fwft_burst: got count %0d want 4", count_f); else passed++;
        reset_f = 1'b1; #1;
        total++; if (count_f !== 5'd0 || empty_f !== 1'b1)
          $display("FAIL fwft_reset_async: got count %0d empty %b want 0 1", count_f, empty_f); else passed++;
      end
    end
    wr_f = 1'b0;
    total++; if (count_f !== 5'd0)
      $display("FAIL fwft_reset_hold: got count %0d want 0", count_f); else passed++;
    reset_f = 1'b0;
    wr_f = 1'b1; wd_f = 8'h11; @(posedge clk); #1;
    wd_f = 8'h22;              @(posedge clk); #1; wr_f = 1'b0;
    total++; if (rdata_f !== 8'h11 || count_f !== 5'd2)
      $display("FAIL fwft_resume: got %0h count %0d want 11 2", rdata_f, count_f); else passed++;
    rd_f = 1'b1; @(posedge clk); #1; rd_f = 1'b0;
    total++; if (rdata_f !== 8'h22)
      $display("FAIL fwft_head: got %0h want 22", rdata_f); else passed++;
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_overflow;
    test_underflow;
    test_back_to_back;
    test_flags;
    test_reset_mid;
    test_fwft;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
